// File: rtl/draw_pkg.sv
// draw_pkg: shared types and constants for the drawing engines
package draw_pkg;
    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_FIN} state_t;
    localparam int BURST_BEATS = 64;
    localparam int BURST_BYTES = 512;
    localparam logic [2:0] VRAM_BASE_TOP = 3'b001;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
endpackage

// File: rtl/draw_vramfill_if.sv
// draw_vramfill_if: AXI AW/W/B write channels of one master port
interface draw_vramfill_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    modport master (
        output awaddr, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );
    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/draw_beatcnt.sv
// draw_beatcnt: beat counter within one burst, flags the last beat
module draw_beatcnt
    import draw_pkg::*;
(
    input  logic ACLK,
    input  logic ARST,
    input  logic inc,
    output logic wlast
);
    logic [$clog2(BURST_BEATS)-1:0] cnt;
    // wraps back to zero on the last beat, ready for the next burst
    always_ff @(posedge ACLK) begin
        if (ARST) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    end
    assign wlast = &cnt;
endmodule

// File: rtl/draw_vramfill.sv
// draw_vramfill: AXI write master painting a VRAM region with one colour in 64-beat bursts
module draw_vramfill
    import draw_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 64
) (
    input  logic        ACLK,
    input  logic        ARST,
    input  logic        START,
    input  logic [28:0] BASEADDR,
    input  logic [15:0] NBURST,
    input  logic [23:0] FILLCOLOR,
    output logic        BUSY,
    output logic        DONE,
    output logic        BRESP_ERR,
    draw_vramfill_if.master m_axi
);
    localparam int SHIFT = $clog2(BURST_BYTES);
    state_t state;
    logic [28-SHIFT:0] addr;
    logic [15:0] remaining;
    logic [23:0] color;
    logic awvalid, wvalid, bready, wlast;
    logic unused_baseaddr;
    assign unused_baseaddr = ^BASEADDR[SHIFT-1:0];
    draw_beatcnt u_beatcnt (
        .ACLK  (ACLK),
        .ARST  (ARST),
        .inc   (wvalid & m_axi.wready),
        .wlast (wlast)
    );
    assign m_axi.awaddr  = C_M_AXI_ADDR_WIDTH'({VRAM_BASE_TOP, addr, {SHIFT{1'b0}}});
    assign m_axi.awvalid = awvalid;
    assign m_axi.wdata   = C_M_AXI_DATA_WIDTH'({8'h00, color, 8'h00, color});
    assign m_axi.wstrb   = {(C_M_AXI_DATA_WIDTH/8){wvalid}};
    assign m_axi.wlast   = wlast;
    assign m_axi.wvalid  = wvalid;
    assign m_axi.bready  = bready;
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
            color     <= '0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            BRESP_ERR <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: if (START) begin
                    addr      <= BASEADDR[28:SHIFT];
                    remaining <= NBURST;
                    color     <= FILLCOLOR;
                    BRESP_ERR <= 1'b0;
                    BUSY      <= 1'b1;
                    awvalid   <= NBURST != 16'd0;
                    state     <= NBURST == 16'd0 ? S_FIN : S_AW;
                end
                S_AW: if (m_axi.awready) begin
                    awvalid <= 1'b0;
                    wvalid  <= 1'b1;
                    state   <= S_W;
                end
                S_W: if (m_axi.wready && wlast) begin
                    wvalid <= 1'b0;
                    bready <= 1'b1;
                    state  <= S_B;
                end
                // address wraps modulo the 512 MB window
                S_B: if (m_axi.bvalid) begin
                    bready    <= 1'b0;
                    remaining <= remaining - 16'd1;
                    addr      <= addr + 1'b1;
                    if (m_axi.bresp != AXI_RESP_OKAY) BRESP_ERR <= 1'b1;
                    if (remaining == 16'd1) begin
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        awvalid <= 1'b1;
                        state   <= S_AW;
                    end
                end
                S_FIN: begin
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
